// File: rtl/yuv_rgb_packer.sv
// YUV->RGB back end: 3-stage fixed-point colour conversion with clipping, then packs
// two RGB pixels into three 16-bit SRAM words with sequential, frame-wrapping addresses.
module yuv_rgb_packer #(
  parameter logic [17:0] RGB_BASE_ADDR = 18'd146944,
  parameter int          FRAME_WORDS   = 115200
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_Y,
  input  logic [7:0]  pix_U,
  input  logic [7:0]  pix_V,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [15:0] wr_data,
  output logic [17:0] wr_address,
  output logic        frame_done,
  output logic [1:0]  pack_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // a producer holding valid keeps its payload stable until that edge.

  localparam logic [1:0]  S_P0    = 2'd0;
  localparam logic [1:0]  S_P1    = 2'd1;
  localparam logic [1:0]  S_FLUSH = 2'd2;
  localparam logic [17:0] LAST_ADDR = RGB_BASE_ADDR + 18'(FRAME_WORDS - 1);

  function automatic logic signed [31:0] sx9(input logic signed [8:0] a);
    return {{23{a[8]}}, a};
  endfunction

  function automatic logic [7:0] clip8(input logic signed [31:0] a);
    if (a[31])
      return 8'd0;
    else if (|a[30:8])
      return 8'hFF;
    else
      return a[7:0];
  endfunction

  logic               s1_valid, s2_valid, s3_valid;
  logic signed [8:0]  s1_y, s1_u, s1_v;
  logic signed [31:0] s2_ry, s2_rv, s2_gu, s2_gv, s2_bu;
  logic [7:0]         s3_r, s3_g, s3_b;
  logic signed [31:0] r_sum, g_sum, b_sum;

  logic [1:0]  state;
  logic [7:0]  b0_hold;
  logic [15:0] g1b1_hold;

  logic reg_free, pack_pixel, s3_take, word_load, wr_fire;
  logic s1_en, s2_en, s3_en, pix_fire;

  // Any stage advances when the stage after it is empty or moving on this cycle.
  assign reg_free   = ~wr_valid | wr_ready;
  assign pack_pixel = (state == S_P0) | (state == S_P1);
  assign s3_take    = s3_valid & reg_free & pack_pixel;
  assign word_load  = s3_take | (~pack_pixel & reg_free);
  assign wr_fire    = wr_valid & wr_ready;
  assign s3_en      = ~s3_valid | s3_take;
  assign s2_en      = ~s2_valid | s3_en;
  assign s1_en      = ~s1_valid | s2_en;
  assign pix_ready  = ~Reset & s1_en;
  assign pix_fire   = pix_valid & pix_ready;
  assign pack_state = state;

  assign r_sum = s2_ry + s2_rv;
  assign g_sum = s2_ry - s2_gu - s2_gv;
  assign b_sum = s2_ry + s2_bu;

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_en) s1_valid <= pix_fire;
      if (s2_en) s2_valid <= s1_valid;
      if (s3_en) s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (pix_fire) begin
      s1_y <= {1'b0, pix_Y} - 9'd16;
      s1_u <= {1'b0, pix_U} - 9'd128;
      s1_v <= {1'b0, pix_V} - 9'd128;
    end
    if (s2_en) begin
      s2_ry <= sx9(s1_y) * 32'sd76284;
      s2_rv <= sx9(s1_v) * 32'sd104595;
      s2_gu <= sx9(s1_u) * 32'sd25624;
      s2_gv <= sx9(s1_v) * 32'sd53281;
      s2_bu <= sx9(s1_u) * 32'sd132251;
    end
    if (s3_en) begin
      s3_r <= clip8(r_sum >>> 16);
      s3_g <= clip8(g_sum >>> 16);
      s3_b <= clip8(b_sum >>> 16);
    end
  end

  // Byte order across a pixel pair: {R0,G0}, {B0,R1}, {G1,B1}.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state     <= S_P0;
      wr_valid  <= 1'b0;
      wr_data   <= 16'd0;
      b0_hold   <= 8'd0;
      g1b1_hold <= 16'd0;
    end else if (word_load) begin
      wr_valid <= 1'b1;
      case (state)
        S_P0: begin
          wr_data <= {s3_r, s3_g};
          b0_hold <= s3_b;
          state   <= S_P1;
        end
        S_P1: begin
          wr_data   <= {b0_hold, s3_r};
          g1b1_hold <= {s3_g, s3_b};
          state     <= S_FLUSH;
        end
        default: begin
          wr_data <= g1b1_hold;
          state   <= S_P0;
        end
      endcase
    end else if (wr_fire) begin
      wr_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      wr_address <= RGB_BASE_ADDR;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wr_fire & (wr_address == LAST_ADDR);
      if (wr_fire) begin
        if (wr_address == LAST_ADDR)
          wr_address <= RGB_BASE_ADDR;
        else
          wr_address <= wr_address + 18'd1;
      end
    end
  end

endmodule

// File: tb/tb_yuv_rgb_packer.sv
// Bench for yuv_rgb_packer: fixed vectors, backpressure, reset-in-flush and random
// frames checked against an arithmetic byte-stream model.
module tb_yuv_rgb_packer;

  localparam logic [17:0] BASE     = 18'd146944;
  localparam int          FW       = 48;
  localparam logic [1:0]  ST_P0    = 2'd0;
  localparam logic [1:0]  ST_FLUSH = 2'd2;

  logic        Clock_50, Reset, pix_valid, pix_ready, wr_valid, wr_ready, frame_done;
  logic [7:0]  pix_Y, pix_U, pix_V;
  logic [15:0] wr_data;
  logic [17:0] wr_address;
  logic [1:0]  pack_state;

  yuv_rgb_packer #(.RGB_BASE_ADDR(BASE), .FRAME_WORDS(FW)) dut (
    .Clock_50(Clock_50), .Reset(Reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_Y(pix_Y), .pix_U(pix_U), .pix_V(pix_V), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_address(wr_address), .frame_done(frame_done),
    .pack_state(pack_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock_50 = 1'b0;
  always #5 Clock_50 = ~Clock_50;

  int cyc = 0;
  always @(posedge Clock_50) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  byte_q[$];
  bit          use_model = 1'b1;
  int          ready_ctl = 0;
  int          word_cnt = 0;
  int          fd_seen = 0;
  int          acc_cyc = 0;
  bit          fd_next = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [17:0] prev_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] clip(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  task automatic model_pixel(input logic [7:0] y8, input logic [7:0] u8, input logic [7:0] v8);
    int y, u, v;
    logic [7:0] hi, lo;
    y = int'(y8) - 16;
    u = int'(u8) - 128;
    v = int'(v8) - 128;
    byte_q.push_back(clip((76284 * y + 104595 * v) >>> 16));
    byte_q.push_back(clip((76284 * y - 25624 * u - 53281 * v) >>> 16));
    byte_q.push_back(clip((76284 * y + 132251 * u) >>> 16));
    while (byte_q.size() >= 2) begin
      hi = byte_q.pop_front();
      lo = byte_q.pop_front();
      exp_q.push_back({hi, lo});
    end
  endtask

  // ---------------- wr_ready driver ----------------
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge Clock_50);
      #2;
      case (ready_ctl)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ($urandom_range(0, 3) != 0);
        default: wr_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [15:0] w;
    forever begin
      @(negedge Clock_50);
      if (Reset) begin
        prev_stall = 1'b0;
        fd_next    = 1'b0;
      end else begin
        check("frame_done", {31'd0, frame_done}, {31'd0, fd_next});
        if (frame_done) fd_seen++;
        fd_next = 1'b0;
        if (prev_stall) begin
          check("hold_valid", {31'd0, wr_valid}, 32'd1);
          check("hold_data", {16'd0, wr_data}, {16'd0, prev_data});
          check("hold_addr", {14'd0, wr_address}, {14'd0, prev_addr});
        end
        if (pix_valid && pix_ready) begin
          acc_cyc = cyc;
          if (use_model) model_pixel(pix_Y, pix_U, pix_V);
        end
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_word actual=%0h required=none", wr_data);
          end else begin
            w = exp_q.pop_front();
            check("wr_data", {16'd0, wr_data}, {16'd0, w});
          end
          check("wr_address", {14'd0, wr_address}, 32'(BASE) + 32'(word_cnt % FW));
          if (word_cnt % FW == FW - 1) fd_next = 1'b1;
          word_cnt++;
        end
        prev_stall = wr_valid && !wr_ready;
        prev_data  = wr_data;
        prev_addr  = wr_address;
      end
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic do_reset();
    Reset = 1'b1;
    pix_valid = 1'b0;
    exp_q.delete();
    byte_q.delete();
    word_cnt = 0;
    @(negedge Clock_50);
    check("ready_in_reset", {31'd0, pix_ready}, 32'd0);
    @(posedge Clock_50);
    #1;
    Reset = 1'b0;
    @(negedge Clock_50);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_wr_address", {14'd0, wr_address}, 32'(BASE));
    check("rst_state", {30'd0, pack_state}, {30'd0, ST_P0});
    @(posedge Clock_50);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    bit acc;
    int k;
    pix_valid = 1'b1;
    pix_Y = y;
    pix_U = u;
    pix_V = v;
    acc = 1'b0;
    for (k = 0; k < 60 && !acc; k++) begin
      @(negedge Clock_50);
      acc = pix_ready;
      @(posedge Clock_50);
      #1;
    end
    pix_valid = 1'b0;
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge Clock_50);
      if (exp_q.size() == 0) break;
    end
    @(posedge Clock_50);
    #1;
    if (k == 300) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  y0, u0, v0, y1, u1, v1;
    logic [15:0] w0, w1, w2;
  } vec_t;

  vec_t vecs[4];
  bit   saw_stall;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    vecs[0] = '{8'd16,  8'd128, 8'd128, 8'd16,  8'd128, 8'd128, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{8'd235, 8'd128, 8'd128, 8'd81,  8'd90,  8'd240, 16'hFEFE, 16'hFEFE, 16'h0000};
    vecs[2] = '{8'd255, 8'd255, 8'd255, 8'd0,   8'd0,   8'd0,   16'hFF7D, 16'hFF00, 16'h8700};
    vecs[3] = '{8'd128, 8'd128, 8'd128, 8'd100, 8'd50,  8'd200, 16'h8282, 16'h82D4, 16'h4500};

    Reset = 1'b1;
    pix_valid = 1'b0;
    pix_Y = 8'd0;
    pix_U = 8'd0;
    pix_V = 8'd0;
    repeat (2) @(posedge Clock_50);
    #1;
    do_reset();

    // first-word latency, black pixels at the base address
    send_pixel(8'd16, 8'd128, 8'd128);
    begin
      int k;
      for (k = 0; k < 12; k++) begin
        @(negedge Clock_50);
        if (wr_valid) break;
      end
      check("latency", 32'(cyc - acc_cyc), 32'd4);
      @(posedge Clock_50);
      #1;
    end
    send_pixel(8'd16, 8'd128, 8'd128);
    drain();

    // fixed vectors with hand-computed words
    use_model = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[i].w0);
      exp_q.push_back(vecs[i].w1);
      exp_q.push_back(vecs[i].w2);
      send_pixel(vecs[i].y0, vecs[i].u0, vecs[i].v0);
      send_pixel(vecs[i].y1, vecs[i].u1, vecs[i].v1);
      drain();
    end
    use_model = 1'b1;

    // 10-cycle output stall mid-stream
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++)
          send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
      end
      begin
        repeat (6) @(posedge Clock_50);
        #1;
        ready_ctl = 2;
        repeat (10) begin
          @(negedge Clock_50);
          if (!pix_ready) saw_stall = 1'b1;
        end
        @(posedge Clock_50);
        #1;
        ready_ctl = 0;
      end
    join
    drain();
    check("stall_pix_ready_dropped", {31'd0, saw_stall}, 32'd1);

    // reset while flushing with a word pending
    ready_ctl = 2;
    @(posedge Clock_50);
    #1;
    send_pixel(8'd200, 8'd60, 8'd180);
    send_pixel(8'd40, 8'd220, 8'd30);
    repeat (6) @(posedge Clock_50);
    #1;
    ready_ctl = 0;
    @(posedge Clock_50);
    #1;
    ready_ctl = 2;
    @(negedge Clock_50);
    check("flush_state", {30'd0, pack_state}, {30'd0, ST_FLUSH});
    check("flush_wr_valid", {31'd0, wr_valid}, 32'd1);
    @(posedge Clock_50);
    #1;
    do_reset();
    ready_ctl = 0;
    send_pixel(8'd235, 8'd128, 8'd128);
    send_pixel(8'd81, 8'd90, 8'd240);
    drain();

    // random pixels and random backpressure across two frame wraps
    do_reset();
    fd_seen = 0;
    ready_ctl = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge Clock_50);
        #1;
      end
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));
    end
    drain();
    ready_ctl = 0;
    repeat (3) @(posedge Clock_50);
    #1;
    check("frame_pulses", 32'(fd_seen), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
